// File: rtl/video_pkg.sv
// Shared video definitions: pattern mode encodings, default geometry and
// the dark-gray level used by the colour-bar pattern.
package video_pkg;

   localparam int unsigned DEF_CW       = 8;
   localparam int unsigned DEF_CNT_W    = 12;
   localparam int unsigned DEF_H_ACTIVE = 1280;
   localparam int unsigned DEF_V_ACTIVE = 720;

   typedef enum logic [2:0] {
      MODE_BARS  = 3'd0,
      MODE_RAMP  = 3'd1,
      MODE_CHECK = 3'd2,
      MODE_BOX   = 3'd3,
      MODE_SOLID = 3'd4
   } mode_e;

   typedef enum logic {
      DIR_POS = 1'b0,
      DIR_NEG = 1'b1
   } dir_e;

   // Dark gray is 1/16 of full scale for any channel width (CW <= 12).
   function automatic logic [11:0] dark_gray(input int unsigned cw);
      return 12'(1) << (cw - 4);
   endfunction

endpackage

// File: rtl/box_mover.sv
// One axis of the bouncing box: advances by STEP on each frame start and
// reverses at 0 and LIMIT-SIZE so the box never leaves the active area.
module box_mover
   import video_pkg::*;
#(
   parameter int unsigned W     = 13,
   parameter int unsigned LIMIT = 1280,
   parameter int unsigned SIZE  = 64,
   parameter int unsigned STEP  = 4
) (
   input  logic         pixel_clk,
   input  logic         reset,
   input  logic         fs,
   output logic [W-1:0] pos,
   output logic         dir
);

   localparam logic [W-1:0] MAX_POS = W'(LIMIT - SIZE);
   localparam logic [W-1:0] STEP_W  = W'(STEP);

   logic [W-1:0] pos_q, pos_d;
   dir_e         dir_q, dir_d;

   always_comb begin
      pos_d = pos_q;
      dir_d = dir_q;
      if (fs) begin
         if (dir_q == DIR_POS) begin
            if (pos_q + STEP_W >= MAX_POS) begin
               pos_d = MAX_POS;
               dir_d = DIR_NEG;
            end else begin
               pos_d = pos_q + STEP_W;
            end
         end else begin
            if (pos_q <= STEP_W) begin
               pos_d = '0;
               dir_d = DIR_POS;
            end else begin
               pos_d = pos_q - STEP_W;
            end
         end
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         pos_q <= '0;
         dir_q <= DIR_POS;
      end else begin
         pos_q <= pos_d;
         dir_q <= dir_d;
      end
   end

   assign pos = pos_q;
   assign dir = dir_q;

endmodule

// File: rtl/pattern_gen.sv
// Video test-pattern generator: two-stage pipeline (decode, colour mux) with
// sync/active delayed to match; pattern mode latched only at frame start.
module pattern_gen
   import video_pkg::*;
#(
   parameter int unsigned CW           = DEF_CW,
   parameter int unsigned CNT_W        = DEF_CNT_W,
   parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
   parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
   parameter int unsigned STRIPE_SHIFT = 6,
   parameter int unsigned CHECK_SHIFT  = 5,
   parameter int unsigned BOX_SIZE     = 64,
   parameter int unsigned STEP         = 4
) (
   input  logic              pixel_clk,
   input  logic              reset,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              active_in,
   input  logic [CNT_W-1:0]  pixel_cnt,
   input  logic [CNT_W-1:0]  line_cnt,
   input  logic [2:0]        mode_sel,
   input  logic [3*CW-1:0]   solid_rgb,
   output logic [CW-1:0]     red,
   output logic [CW-1:0]     green,
   output logic [CW-1:0]     blue,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              active_out,
   output logic [7:0]        frame_cnt
);

   localparam int unsigned   BW   = CNT_W + 1;
   localparam logic [CW-1:0] GRAY = CW'(dark_gray(CW));

   logic          vs_prev_q, fs;
   logic [2:0]    mode_q, mode_d;
   logic [7:0]    frame_q, frame_d;
   logic [BW-1:0] box_x, box_y;
   logic          box_dx, box_dy;

   // Stage 1: timing, pattern mode and per-pixel decode terms
   logic              hs1_q, vs1_q, act1_q, chk1_q, in_box1_q;
   logic [2:0]        mode1_q, bar_idx1_q;
   logic [CW-1:0]     ramp1_q, xlo1_q;
   logic [3*CW-1:0]   solid1_q;
   logic              in_box_d;
   logic [BW-1:0]     x_ext, y_ext;
   logic [STRIPE_SHIFT+CW-1:0] ramp_ext;

   // Stage 2: output registers
   logic              hs2_q, vs2_q, act2_q;
   logic [3*CW-1:0]   rgb2_q, rgb_d, bars_rgb;

   assign fs      = vsync_in & ~vs_prev_q;
   assign mode_d  = fs ? mode_sel : mode_q;
   assign frame_d = fs ? frame_q + 8'd1 : frame_q;

   box_mover #(.W(BW), .LIMIT(H_ACTIVE), .SIZE(BOX_SIZE), .STEP(STEP)) u_box_x (
      .pixel_clk (pixel_clk),
      .reset     (reset),
      .fs        (fs),
      .pos       (box_x),
      .dir       (box_dx)
   );

   box_mover #(.W(BW), .LIMIT(V_ACTIVE), .SIZE(BOX_SIZE), .STEP(STEP)) u_box_y (
      .pixel_clk (pixel_clk),
      .reset     (reset),
      .fs        (fs),
      .pos       (box_y),
      .dir       (box_dy)
   );

   always_comb begin
      x_ext    = {1'b0, pixel_cnt};
      y_ext    = {1'b0, line_cnt};
      in_box_d = (x_ext >= box_x) && (x_ext < box_x + BW'(BOX_SIZE)) &&
                 (y_ext >= box_y) && (y_ext < box_y + BW'(BOX_SIZE));
      // Stripe-local ramp is MSB-aligned: pads or truncates to CW bits.
      ramp_ext = {pixel_cnt[STRIPE_SHIFT-1:0], {CW{1'b0}}};
   end

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         vs_prev_q  <= 1'b0;
         mode_q     <= '0;
         frame_q    <= '0;
         hs1_q      <= 1'b0;
         vs1_q      <= 1'b0;
         act1_q     <= 1'b0;
         chk1_q     <= 1'b0;
         in_box1_q  <= 1'b0;
         mode1_q    <= '0;
         bar_idx1_q <= '0;
         ramp1_q    <= '0;
         xlo1_q     <= '0;
         solid1_q   <= '0;
      end else begin
         vs_prev_q  <= vsync_in;
         mode_q     <= mode_d;
         frame_q    <= frame_d;
         hs1_q      <= hsync_in;
         vs1_q      <= vsync_in;
         act1_q     <= active_in;
         chk1_q     <= pixel_cnt[CHECK_SHIFT] ^ line_cnt[CHECK_SHIFT];
         in_box1_q  <= in_box_d;
         mode1_q    <= mode_q;
         bar_idx1_q <= pixel_cnt[STRIPE_SHIFT+2:STRIPE_SHIFT];
         ramp1_q    <= ramp_ext[STRIPE_SHIFT+CW-1 -: CW];
         xlo1_q     <= pixel_cnt[CW-1:0];
         solid1_q   <= solid_rgb;
      end
   end

   always_comb begin
      if (bar_idx1_q == 3'd0) begin
         bars_rgb = {GRAY, GRAY, GRAY};
      end else begin
         bars_rgb = {bar_idx1_q[2] ? ramp1_q : '0,
                     bar_idx1_q[1] ? ramp1_q : '0,
                     bar_idx1_q[0] ? ramp1_q : '0};
      end
      rgb_d = '0;
      case (mode1_q)
         MODE_BARS:  rgb_d = bars_rgb;
         MODE_RAMP:  rgb_d = {xlo1_q, xlo1_q, xlo1_q};
         MODE_CHECK: rgb_d = chk1_q ? '1 : '0;
         MODE_BOX:   rgb_d = in_box1_q ? '1 : bars_rgb;
         MODE_SOLID: rgb_d = solid1_q;
         default:    rgb_d = '0;
      endcase
      if (!act1_q) begin
         rgb_d = '0;
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         hs2_q  <= 1'b0;
         vs2_q  <= 1'b0;
         act2_q <= 1'b0;
         rgb2_q <= '0;
      end else begin
         hs2_q  <= hs1_q;
         vs2_q  <= vs1_q;
         act2_q <= act1_q;
         rgb2_q <= rgb_d;
      end
   end

   assign red        = rgb2_q[3*CW-1:2*CW];
   assign green      = rgb2_q[2*CW-1:CW];
   assign blue       = rgb2_q[CW-1:0];
   assign hsync_out  = hs2_q;
   assign vsync_out  = vs2_q;
   assign active_out = act2_q;
   assign frame_cnt  = frame_q;

endmodule

// File: doc/pattern_gen.md
Name: pattern_gen

Overview:
- Parametrised video test-pattern generator; successor to the fixed colour-stripe logic in the HDMI top level.
- Sits between hvsync and HDMI. Takes timing (syncs, active, pixel/line counters) and produces CW-bit RGB plus sync/active delayed to match.
- Supports colour bars, ramp, checkerboard, bouncing box over bars, and a programmable solid colour.
- Mode changes take effect only at frame boundaries (no tearing).

Parameters:
- CW, 8: colour channel width, 4..12.
- CNT_W, 12: pixel_cnt/line_cnt width.
- H_ACTIVE, 1280: active pixels per line.
- V_ACTIVE, 720: active lines per frame.
- STRIPE_SHIFT, 6: log2 of colour-bar stripe width in pixels.
- CHECK_SHIFT, 5: log2 of checkerboard square size.
- BOX_SIZE, 64: moving-box edge length in pixels.
- STEP, 4: box displacement per frame, pixels per axis.

Ports:
- pixel_clk  in  1  pixel clock; only clock.
- reset  in  1  synchronous, active-high reset.
- hsync_in  in  1  horizontal sync, active-high.
- vsync_in  in  1  vertical sync, active-high.
- active_in  in  1  active video region.
- pixel_cnt  in  CNT_W  current pixel x, 0-based within active.
- line_cnt  in  CNT_W  current line y.
- mode_sel  in  3  requested pattern mode (encoding under Behaviour).
- solid_rgb  in  3*CW  {R,G,B} for solid mode.
- red/green/blue  out  CW each  pixel colour.
- hsync_out/vsync_out/active_out  out  1 each  timing delayed to align with RGB.
- frame_cnt  out  8  frames since reset, wraps 255->0.

Behaviour:
- Single domain: pixel_clk. Reset is synchronous and active-high; the clock is pixel_clk and the reset is reset.
- Reset values:
  - All outputs 0; pipeline registers 0.
  - mode_q = 0.
  - box_x = box_y = 0; dx = dy = +.
  - vsync edge detector = 0.
- Latency: exactly 2 cycles from input sample to red/green/blue and *_out. Syncs and active go through an identical 2-stage delay.
- Stage 1 registers counters, active and decode terms. Stage 2 registers the colour mux.
- Frame start (fs): vsync_in=1 while the previous-cycle vsync_in=0. On fs, in one cycle:
  - mode_q <= mode_sel;
  - frame_cnt++;
  - box advances.
  - Pixels already in the pipeline keep their old mode.
- Modes (mode_q):
  - 0, bars: idx = pixel_cnt[STRIPE_SHIFT+2:STRIPE_SHIFT].
    - idx 0: dark gray, all channels = 1<<(CW-4).
    - Otherwise ramp = pixel_cnt[STRIPE_SHIFT-1:0], MSB-aligned into CW bits (zero-padded or LSB-truncated).
    - R = idx[2]?ramp:0; G = idx[1]?ramp:0; B = idx[0]?ramp:0.
  - 1, ramp: all channels = pixel_cnt[CW-1:0]; wraps.
  - 2, checker: pixel_cnt[CHECK_SHIFT]^line_cnt[CHECK_SHIFT] ? all-ones : 0.
  - 3, box: white (all-ones) where box_x<=x<box_x+BOX_SIZE and box_y<=y<box_y+BOX_SIZE; mode-0 bars elsewhere.
  - 4, solid: solid_rgb.
  - 5..7: black.
- active_in=0 forces RGB = 0 regardless of mode.
- Box motion on fs, per axis (x shown; y identical with V_ACTIVE):
  - dx=+: if box_x+STEP >= H_ACTIVE-BOX_SIZE then box_x <= H_ACTIVE-BOX_SIZE and dx <= −; else box_x += STEP.
  - dx=−: if box_x <= STEP then box_x <= 0 and dx <= +; else box_x −= STEP.
  - Box never leaves the active area.
  - Box arithmetic is CNT_W+1 bits wide to avoid wrap.
- Reset mid-frame:
  - Outputs are 0 in the cycle after reset is sampled.
  - Mode 0 is used until the first fs after reset.
  - The pipeline refills within 2 cycles of reset deassert.
- Asynchronous mode_sel changes are tolerated; mode_sel is sampled only on fs.

Decomposition:
- Shared package video_pkg:
  - mode encodings MODE_BARS=0, MODE_RAMP=1, MODE_CHECK=2, MODE_BOX=3, MODE_SOLID=4;
  - default CW/CNT_W/H_ACTIVE/V_ACTIVE constants;
  - dark-gray helper function.
- Sub-module box_mover: one instance per axis.
  - Parameters: LIMIT, SIZE, STEP.
  - Ports: pixel_clk, reset, fs, pos, dir.

Test Plan:
- Mode 0, active, pixel_cnt=0 -> RGB 10/10/10 two cycles later. pixel_cnt=0x150 -> R=40,G=00,B=40. pixel_cnt=0x1E0 -> 80/80/80.
- Mode 2: (x=32,y=0) -> FF/FF/FF; (x=32,y=32) -> 00/00/00; (x=0,y=0) -> 00/00/00.
- Mode 3, 400 frame pulses. box_x after n fs:
  - n=1: 4.
  - n=303: 1212.
  - n=304: 1216, dx flips.
  - n=305: 1212.
  - Pixel (box_x, box_y) is FF/FF/FF; pixel (box_x+64, box_y) is a bar colour.
- mode_sel changes 0->4 (solid_rgb=0x123456) at line 100 -> mode-0 output until the next vsync rise, then 12/34/56 for the whole frame; frame_cnt increments by exactly 1.
- Random syncs/active: hsync_out/vsync_out/active_out equal inputs delayed exactly 2 cycles. RGB = 0 whenever active_out=0.
- reset pulsed 1 cycle mid-frame in mode 3 -> next cycle all outputs 0, frame_cnt=0, box at (0,0); mode 0 until next fs.
